// File: rtl/sprite_bank_writer_if.sv
// Sprite bank writer bus interface.
// Purpose: bundles the processor-side write request signals, the blanking
// input and the bank write port of the sprite register bank writer.
// Ports (signals):
//   wr_req/wr_addr/wr_data  processor write request (master -> slave)
//   wr_ack/wr_rej           accept/reject pulses (slave -> master)
//   full, busy              FIFO / controller status
//   blank                   display blanking indicator (master -> slave)
//   compare                 comparators forced idle while bank is written
//   bank_we/addr/data       bank write port
interface sprite_bank_writer_if #(
  parameter int ADDR_W   = 5,
  parameter int SIZE_REG = 32
);
  logic                wr_req;
  logic [ADDR_W-1:0]   wr_addr;
  logic [SIZE_REG-1:0] wr_data;
  logic                wr_ack;
  logic                wr_rej;
  logic                full;
  logic                blank;
  logic                compare;
  logic                bank_we;
  logic [ADDR_W-1:0]   bank_addr;
  logic [SIZE_REG-1:0] bank_data;
  logic                busy;

  modport master (
    output wr_req, wr_addr, wr_data, blank,
    input  wr_ack, wr_rej, full, compare, bank_we, bank_addr, bank_data, busy
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, blank,
    output wr_ack, wr_rej, full, compare, bank_we, bank_addr, bank_data, busy
  );
endinterface

// File: rtl/sprite_bank_writer.sv
// Sprite register bank write-side controller.
// Purpose: validates sprite register updates, buffers them in a small FIFO
// and commits them to the bank only during display blanking, holding
// `compare` high around the commit burst so comparators stay idle.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    sprite_bank_writer_if.slave (request, status and bank write port)
module sprite_bank_writer #(
  parameter int SIZE_REG   = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int X_MAX      = 639,
  parameter int Y_MAX      = 479
) (
  input logic                 clk,
  input logic                 reset,
  sprite_bank_writer_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [9:0]     X_MAX_L = 10'(X_MAX);
  localparam logic [9:0]     Y_MAX_L = 10'(Y_MAX);

  typedef enum logic [1:0] {IDLE, ARM, WRITE, RELEASE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_mem_q [FIFO_DEPTH];
  logic [SIZE_REG-1:0] data_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr_q, rptr_q;
  logic [PTR_W:0]      count_q, count_d;
  logic                ack_q, rej_q;

  logic full, empty, coord_ok, push, reject, pop;

  assign full  = (count_q == DEPTH_L);
  assign empty = (count_q == '0);

  // Inactive words bypass the coordinate check entirely.
  assign coord_ok = !bus.wr_data[29] ||
                    ((bus.wr_data[28:19] <= X_MAX_L) && (bus.wr_data[18:9] <= Y_MAX_L));

  // Full is judged on the pre-edge count, so a pop on the same edge never
  // opens room for a push.
  assign push   = bus.wr_req && !full && coord_ok;
  assign reject = bus.wr_req && !full && !coord_ok;
  assign pop    = (state_q == WRITE);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wptr_q] <= bus.wr_addr;
      data_mem_q[wptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
      rej_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      ack_q   <= push;
      rej_q   <= reject;
      state_q <= state_d;
    end
  end

  // Commit sequencing: one guard cycle before and after each burst. The burst
  // continues while entries remain after this edge (a same-edge push counts)
  // and blanking is still asserted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty && bus.blank) state_d = ARM;
      ARM:     state_d = WRITE;
      WRITE:   state_d = ((count_d != '0) && bus.blank) ? WRITE : RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.wr_ack    = ack_q;
  assign bus.wr_rej    = rej_q;
  assign bus.full      = full;
  assign bus.compare   = (state_q != IDLE);
  assign bus.bank_we   = (state_q == WRITE);
  assign bus.bank_addr = (state_q == WRITE) ? addr_mem_q[rptr_q] : '0;
  assign bus.bank_data = (state_q == WRITE) ? data_mem_q[rptr_q] : '0;
  assign bus.busy      = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_sprite_bank_writer.sv
// Testbench for sprite_bank_writer: randomized and directed traffic checked
// cycle by cycle against a queue-based behavioural model.
module tb_sprite_bank_writer;

  logic clk;
  logic reset;

  sprite_bank_writer_if #(.ADDR_W(5), .SIZE_REG(32)) bus ();

  sprite_bank_writer #(
    .SIZE_REG(32), .ADDR_W(5), .FIFO_DEPTH(4), .X_MAX(639), .Y_MAX(479)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } entry_t;

  entry_t mq[$];
  int     mPhase;      // 0 quiet, 1 guard before burst, 2 committing, 3 guard after
  logic   expAck, expRej;
  int     checkCount = 0;
  int     errorCount = 0;
  int     writesSeen;

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compare every DUT output with what the model says should be visible now
  task automatic compareAll();
    logic        we;
    logic [4:0]  ea;
    logic [31:0] ed;
    we = (mPhase == 2) && (mq.size() > 0);
    ea = we ? mq[0].a : 5'd0;
    ed = we ? mq[0].d : 32'd0;
    checkOutput("wr_ack", 32'(bus.wr_ack), 32'(expAck));
    checkOutput("wr_rej", 32'(bus.wr_rej), 32'(expRej));
    checkOutput("full", 32'(bus.full), 32'(mq.size() == 4));
    checkOutput("compare", 32'(bus.compare), 32'(mPhase != 0));
    checkOutput("bank_we", 32'(bus.bank_we), 32'(mPhase == 2));
    checkOutput("bank_addr", 32'(bus.bank_addr), 32'(ea));
    checkOutput("bank_data", bus.bank_data, ed);
    checkOutput("busy", 32'(bus.busy), 32'((mq.size() > 0) || (mPhase != 0)));
  endtask

  // Advance the model by one edge using the currently driven inputs, then
  // wait for that edge and check the DUT just after it
  task automatic applyStimulus();
    logic        isFull, valid, hadEntries;
    logic [31:0] d;
    entry_t      tmp;
    if (reset) begin
      mq.delete();
      mPhase = 0;
      expAck = 1'b0;
      expRej = 1'b0;
    end else begin
      d          = bus.wr_data;
      isFull     = (mq.size() == 4);
      hadEntries = (mq.size() > 0);
      valid      = !(d[29] && ((int'(d[28:19]) > 639) || (int'(d[18:9]) > 479)));
      expAck     = bus.wr_req && !isFull && valid;
      expRej     = bus.wr_req && !isFull && !valid;
      if (mPhase == 2 && mq.size() > 0) begin
        tmp = mq.pop_front();
        writesSeen++;
      end
      if (expAck) begin
        tmp.a = bus.wr_addr;
        tmp.d = d;
        mq.push_back(tmp);
      end
      case (mPhase)
        0:       mPhase = (hadEntries && bus.blank) ? 1 : 0;
        1:       mPhase = 2;
        2:       mPhase = ((mq.size() > 0) && bus.blank) ? 2 : 3;
        default: mPhase = 0;
      endcase
    end
    @(posedge clk);
    #1;
    compareAll();
  endtask

  function automatic logic [31:0] genData(input logic forceActive, input logic forceLegal);
    logic [9:0] x, y;
    logic       act;
    int         r;
    r = $urandom_range(0, 3);
    x = (r == 0) ? 10'd639 : (r == 1) ? 10'd640 : 10'($urandom_range(0, 700));
    r = $urandom_range(0, 3);
    y = (r == 0) ? 10'd479 : (r == 1) ? 10'd480 : 10'($urandom_range(0, 520));
    act = forceActive ? 1'b1 : 1'($urandom);
    if (forceLegal) begin
      if (x > 10'd639) x = 10'd639;
      if (y > 10'd479) y = 10'd479;
    end
    return {2'($urandom), act, x, y, 9'($urandom)};
  endfunction

  task automatic request(input logic [4:0] a, input logic [31:0] d);
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    applyStimulus();
    bus.wr_req  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  int reachWrite;

  initial begin
    reset       = 1'b1;
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.blank   = 1'b0;
    mq.delete();
    mPhase      = 0;
    expAck      = 1'b0;
    expRej      = 1'b0;
    writesSeen  = 0;

    // Reset state
    idleCycles(2);
    reset = 1'b0;
    idleCycles(1);

    // Single write with minimum latency
    bus.blank = 1'b1;
    request(5'd3, 32'h2000_0000 | (32'd100 << 19) | (32'd50 << 9));
    idleCycles(6);

    // Validation boundaries
    request(5'd4, 32'h2000_0000 | (32'd640 << 19) | (32'd10 << 9));
    idleCycles(2);
    request(5'd5, (32'd640 << 19) | (32'd10 << 9));
    idleCycles(5);
    request(5'd6, 32'h2000_0000 | (32'd639 << 19) | (32'd479 << 9));
    request(5'd7, 32'h2000_0000 | (32'd10 << 19) | (32'd480 << 9));
    idleCycles(6);

    // Backpressure: five requests while not blanking, then one burst
    bus.blank = 1'b0;
    for (int i = 0; i < 5; i++) request(5'(i + 8), genData(1'b1, 1'b1));
    idleCycles(2);
    bus.blank = 1'b1;
    idleCycles(10);

    // Blank drop after the second committed write of a four-entry burst
    bus.blank = 1'b0;
    for (int i = 0; i < 4; i++) request(5'd20, genData(1'b0, 1'b1));
    bus.blank  = 1'b1;
    writesSeen = 0;
    for (int i = 0; i < 20 && writesSeen < 2; i++) begin
      applyStimulus();
      if (mPhase == 2 && writesSeen == 1) bus.blank = 1'b0;
    end
    idleCycles(4);
    bus.blank = 1'b1;
    idleCycles(8);

    // Push while a burst is committing
    bus.blank = 1'b0;
    for (int i = 0; i < 2; i++) request(5'(i), genData(1'b1, 1'b1));
    bus.blank = 1'b1;
    idleCycles(2);
    request(5'd2, genData(1'b1, 1'b1));
    idleCycles(8);

    // Randomized traffic with long blanking runs
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 15) == 0) bus.blank = ~bus.blank;
      bus.wr_req  = ($urandom_range(0, 2) != 0);
      bus.wr_addr = 5'($urandom);
      bus.wr_data = genData(1'b0, 1'b0);
      applyStimulus();
    end
    bus.wr_req = 1'b0;
    idleCycles(10);

    // Asynchronous reset while committing
    bus.blank = 1'b0;
    for (int i = 0; i < 3; i++) request(5'(i + 9), genData(1'b1, 1'b1));
    bus.blank  = 1'b1;
    reachWrite = 0;
    for (int i = 0; i < 20 && reachWrite == 0; i++) begin
      applyStimulus();
      if (mPhase == 2) reachWrite = 1;
    end
    checkOutput("reach_write", 32'(reachWrite), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_bank_we", 32'(bus.bank_we), 32'd0);
    checkOutput("async_compare", 32'(bus.compare), 32'd0);
    checkOutput("async_busy", 32'(bus.busy), 32'd0);
    checkOutput("async_bank_data", bus.bank_data, 32'd0);
    idleCycles(2);
    reset = 1'b0;
    idleCycles(8);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
